// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared CPU defines for opcodes, funct fields and ALU op/select codes.
package decode_stage_pkg;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    typedef enum logic [7:0] {
        ALU_NOP  = 8'h00,
        ALU_ADD  = 8'h01,
        ALU_SUB  = 8'h02,
        ALU_SLL  = 8'h03,
        ALU_SLT  = 8'h04,
        ALU_SLTU = 8'h05,
        ALU_XOR  = 8'h06,
        ALU_SRL  = 8'h07,
        ALU_SRA  = 8'h08,
        ALU_OR   = 8'h09,
        ALU_AND  = 8'h0A
    } aluop_e;
    typedef enum logic [2:0] {
        SEL_NOP   = 3'd0,
        SEL_ARITH = 3'd1,
        SEL_LOGIC = 3'd2,
        SEL_SHIFT = 3'd3,
        SEL_CMP   = 3'd4
    } alusel_e;
    // alt selects SUB/SRA; callers must only set it where funct7 actually carries that meaning
    function automatic aluop_e f3_aluop(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
    function automatic alusel_e f3_alusel(input logic [2:0] f3);
        return (f3 == F3_ADD) ? SEL_ARITH :
               (f3 == F3_SLL || f3 == F3_SR) ? SEL_SHIFT :
               (f3 == F3_SLT || f3 == F3_SLTU) ? SEL_CMP : SEL_LOGIC;
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: registered decode result bundle with its valid/ready handshake.
interface decode_stage_if #(parameter int XLEN = 32);
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      aluop_o;
    logic [2:0]      alusel_o;
    logic [XLEN-1:0] op1_o;
    logic [XLEN-1:0] op2_o;
    logic            we_o;
    logic [4:0]      waddr_o;
    logic [XLEN-1:0] pc_o;
    logic            illegal_o;
    modport master (output out_valid, aluop_o, alusel_o, op1_o, op2_o, we_o, waddr_o, pc_o, illegal_o,
                    input out_ready);
    modport slave (input out_valid, aluop_o, alusel_o, op1_o, op2_o, we_o, waddr_o, pc_o, illegal_o,
                   output out_ready);
endinterface

// File: rtl/decode_stage_operand_fwd.sv
// operand_fwd: resolves one source register from forwarding slots (lowest index wins) or regfile.
module operand_fwd #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic [4:0]            addr,
    input  logic [XLEN-1:0]       rf_data,
    input  logic [NUM_FWD-1:0]    fwd_we,
    input  logic [5*NUM_FWD-1:0]  fwd_addr,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    output logic [XLEN-1:0]       data
);
    always_comb begin
        data = rf_data;
        for (int i = NUM_FWD - 1; i >= 0; i--)
            if (fwd_we[i] && fwd_addr[i*5 +: 5] == addr) data = fwd_data[i*XLEN +: XLEN];
        if (addr == 5'd0) data = '0;
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I OP/OP-IMM/LUI/AUIPC decoder with operand forwarding and load-use stall.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [31:0]             inst_i,
    output logic                    r1_en_o,
    output logic                    r2_en_o,
    output logic [4:0]              r1_addr_o,
    output logic [4:0]              r2_addr_o,
    input  logic [XLEN-1:0]         r1_data_i,
    input  logic [XLEN-1:0]         r2_data_i,
    input  logic [NUM_FWD-1:0]      fwd_we_i,
    input  logic [5*NUM_FWD-1:0]    fwd_addr_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
    input  logic                    ex_load_i,
    input  logic                    flush_i,
    decode_stage_if.master          dout
);
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
    logic is_op, is_imm, is_lui, is_auipc, is_u, alt, legal, use1, use2;
    logic hazard, load_stall, accept;
    logic [7:0] aluop;
    logic [2:0] alusel;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_u, shamt, op1, op2;
    assign opcode   = inst_i[6:0];
    assign rd       = inst_i[11:7];
    assign f3       = inst_i[14:12];
    assign rs1      = inst_i[19:15];
    assign rs2      = inst_i[24:20];
    assign f7       = inst_i[31:25];
    assign is_op    = opcode == OPC_OP;
    assign is_imm   = opcode == OPC_OP_IMM;
    assign is_lui   = opcode == OPC_LUI;
    assign is_auipc = opcode == OPC_AUIPC;
    assign is_u     = is_lui || is_auipc;
    assign alt      = f7 == F7_ALT;
    // OP-IMM only constrains funct7 on shifts; OP allows the alternate funct7 on ADD/SR only
    assign legal = is_op  ? (f7 == F7_BASE || (alt && (f3 == F3_ADD || f3 == F3_SR))) :
                   is_imm ? (f3 == F3_SLL ? f7 == F7_BASE : (f3 != F3_SR || f7 == F7_BASE || alt)) :
                   is_u;
    assign use1      = legal && (is_op || is_imm);
    assign use2      = legal && is_op;
    assign r1_en_o   = in_valid && use1;
    assign r2_en_o   = in_valid && use2;
    assign r1_addr_o = rs1;
    assign r2_addr_o = rs2;
    assign aluop  = !legal ? ALU_NOP : is_u ? ALU_ADD : f3_aluop(f3, alt && (is_op || f3 == F3_SR));
    assign alusel = !legal ? SEL_NOP : is_u ? SEL_ARITH : f3_alusel(f3);
    assign imm_i  = XLEN'($signed(inst_i[31:20]));
    assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign shamt  = XLEN'(inst_i[24:20]);
    operand_fwd #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd1 (
        .addr(rs1), .rf_data(r1_data_i), .fwd_we(fwd_we_i), .fwd_addr(fwd_addr_i),
        .fwd_data(fwd_data_i), .data(rs1_val)
    );
    operand_fwd #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd2 (
        .addr(rs2), .rf_data(r2_data_i), .fwd_we(fwd_we_i), .fwd_addr(fwd_addr_i),
        .fwd_data(fwd_data_i), .data(rs2_val)
    );
    assign op1 = is_auipc ? pc_i : use1 ? rs1_val : '0;
    assign op2 = use2 ? rs2_val : is_u ? imm_u : !legal ? '0 :
                 (f3 == F3_SLL || f3 == F3_SR) ? shamt : imm_i;
    assign hazard = ex_load_i && fwd_we_i[0] &&
                    ((use1 && rs1 != 5'd0 && fwd_addr_i[4:0] == rs1) ||
                     (use2 && rs2 != 5'd0 && fwd_addr_i[4:0] == rs2));
    assign load_stall = in_valid && hazard;
    assign in_ready   = (!dout.out_valid || dout.out_ready) && !load_stall;
    assign accept     = in_valid && in_ready && !flush_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            dout.out_valid <= 1'b0;
            dout.we_o      <= 1'b0;
            dout.waddr_o   <= '0;
            dout.aluop_o   <= ALU_NOP;
            dout.alusel_o  <= SEL_NOP;
            dout.op1_o     <= '0;
            dout.op2_o     <= '0;
            dout.pc_o      <= '0;
            dout.illegal_o <= 1'b0;
        end else if (flush_i) begin
            dout.out_valid <= 1'b0;
        end else if (accept) begin
            dout.out_valid <= 1'b1;
            dout.we_o      <= legal && rd != 5'd0;
            dout.waddr_o   <= rd;
            dout.aluop_o   <= aluop;
            dout.alusel_o  <= alusel;
            dout.op1_o     <= op1;
            dout.op2_o     <= op2;
            dout.pc_o      <= pc_i;
            dout.illegal_o <= !legal;
        end else if (!dout.out_valid || dout.out_ready) begin
            dout.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed table, corner sequences and randomized checks against a pattern-table model.
module tb_decode_stage;
    import decode_stage_pkg::*;
    localparam int XLEN = 32;
    localparam int NF   = 2;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, r1_en, r2_en, ex_load, flush;
    logic [31:0] pc_i, inst_i, r1_data, r2_data;
    logic [4:0] r1_addr, r2_addr;
    logic [NF-1:0] fwd_we;
    logic [5*NF-1:0] fwd_addr;
    logic [XLEN*NF-1:0] fwd_data;
    logic [31:0] rf[32];
    int vectors = 0, miscompares = 0;

    assign r1_data = rf[r1_addr];
    assign r2_data = rf[r2_addr];

    decode_stage_if #(.XLEN(XLEN)) dif();

    decode_stage #(.XLEN(XLEN), .NUM_FWD(NF)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
        .r1_en_o(r1_en), .r2_en_o(r2_en), .r1_addr_o(r1_addr), .r2_addr_o(r2_addr),
        .r1_data_i(r1_data), .r2_data_i(r2_data), .fwd_we_i(fwd_we), .fwd_addr_i(fwd_addr),
        .fwd_data_i(fwd_data), .ex_load_i(ex_load), .flush_i(flush), .dout(dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mask, match;
        logic [7:0]  op;
        logic [2:0]  sel;
        int          kind;
    } pat_t;
    pat_t pats[21];

    typedef struct {
        logic        illegal, we, use1, use2;
        logic [4:0]  waddr;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] op1, op2;
    } exp_t;

    typedef struct {
        logic [31:0] inst, pc;
        logic [1:0]  fwe;
        logic [4:0]  fa0;
        logic [31:0] fd0;
        logic [4:0]  fa1;
        logic [31:0] fd1;
        logic        ill, we;
        logic [4:0]  waddr;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] op1, op2;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] res(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        for (int i = 0; i < NF; i++)
            if (fwd_we[i] && fwd_addr[i*5 +: 5] == a) return fwd_data[i*32 +: 32];
        return rf[a];
    endfunction

    // kinds: 0 I-imm, 1 shift-imm, 2 register, 3 LUI, 4 AUIPC
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int k = -1;
        e = '{default: '0};
        e.illegal = 1'b1;
        e.aluop = ALU_NOP;
        e.alusel = SEL_NOP;
        for (int j = 0; j < 21; j++) if ((inst & pats[j].mask) == pats[j].match) k = j;
        if (k >= 0) begin
            e.illegal = 1'b0;
            e.aluop = pats[k].op;
            e.alusel = pats[k].sel;
            e.waddr = inst[11:7];
            e.we = inst[11:7] != 5'd0;
            e.use1 = pats[k].kind <= 2;
            e.use2 = pats[k].kind == 2;
            e.op1 = pats[k].kind == 4 ? pc : e.use1 ? res(inst[19:15]) : 32'd0;
            case (pats[k].kind)
                0: e.op2 = {{20{inst[31]}}, inst[31:20]};
                1: e.op2 = {27'd0, inst[24:20]};
                2: e.op2 = res(inst[24:20]);
                default: e.op2 = {inst[31:12], 12'd0};
            endcase
        end
        return e;
    endfunction

    function automatic logic haz(input exp_t e, input logic [31:0] inst);
        return ex_load && fwd_we[0] &&
               ((e.use1 && inst[19:15] != 5'd0 && fwd_addr[4:0] == inst[19:15]) ||
                (e.use2 && inst[24:20] != 5'd0 && fwd_addr[4:0] == inst[24:20]));
    endfunction

    task automatic check_out(input string tag, input exp_t e, input logic [31:0] pc);
        chk({tag, ".illegal"}, {31'd0, dif.illegal_o}, {31'd0, e.illegal});
        chk({tag, ".we"}, {31'd0, dif.we_o}, {31'd0, e.we});
        chk({tag, ".aluop"}, {24'd0, dif.aluop_o}, {24'd0, e.aluop});
        chk({tag, ".alusel"}, {29'd0, dif.alusel_o}, {29'd0, e.alusel});
        chk({tag, ".pc"}, dif.pc_o, pc);
        if (!e.illegal) begin
            chk({tag, ".waddr"}, {27'd0, dif.waddr_o}, {27'd0, e.waddr});
            chk({tag, ".op1"}, dif.op1_o, e.op1);
            chk({tag, ".op2"}, dif.op2_o, e.op2);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".valid"}, {31'd0, dif.out_valid}, 32'd0);
        chk({tag, ".we"}, {31'd0, dif.we_o}, 32'd0);
        chk({tag, ".waddr"}, {27'd0, dif.waddr_o}, 32'd0);
        chk({tag, ".aluop"}, {24'd0, dif.aluop_o}, {24'd0, ALU_NOP});
        chk({tag, ".alusel"}, {29'd0, dif.alusel_o}, {29'd0, SEL_NOP});
        chk({tag, ".op1"}, dif.op1_o, 32'd0);
        chk({tag, ".op2"}, dif.op2_o, 32'd0);
        chk({tag, ".pc"}, dif.pc_o, 32'd0);
        chk({tag, ".illegal"}, {31'd0, dif.illegal_o}, 32'd0);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [1:0] fwe,
                         input logic [4:0] fa0, input logic [31:0] fd0,
                         input logic [4:0] fa1, input logic [31:0] fd1);
        inst_i = inst;
        pc_i = pc;
        fwd_we = fwe;
        fwd_addr = {fa1, fa0};
        fwd_data = {fd1, fd0};
    endtask

    initial begin
        exp_t e, m;
        logic [31:0] m_pc, snap_op1, snap_op2, snap_pc;
        logic m_valid, rdy, hz;
        pats = '{
            '{32'h0000707F, 32'h00000013, ALU_ADD,  SEL_ARITH, 0},
            '{32'h0000707F, 32'h00002013, ALU_SLT,  SEL_CMP,   0},
            '{32'h0000707F, 32'h00003013, ALU_SLTU, SEL_CMP,   0},
            '{32'h0000707F, 32'h00004013, ALU_XOR,  SEL_LOGIC, 0},
            '{32'h0000707F, 32'h00006013, ALU_OR,   SEL_LOGIC, 0},
            '{32'h0000707F, 32'h00007013, ALU_AND,  SEL_LOGIC, 0},
            '{32'hFE00707F, 32'h00001013, ALU_SLL,  SEL_SHIFT, 1},
            '{32'hFE00707F, 32'h00005013, ALU_SRL,  SEL_SHIFT, 1},
            '{32'hFE00707F, 32'h40005013, ALU_SRA,  SEL_SHIFT, 1},
            '{32'hFE00707F, 32'h00000033, ALU_ADD,  SEL_ARITH, 2},
            '{32'hFE00707F, 32'h40000033, ALU_SUB,  SEL_ARITH, 2},
            '{32'hFE00707F, 32'h00001033, ALU_SLL,  SEL_SHIFT, 2},
            '{32'hFE00707F, 32'h00002033, ALU_SLT,  SEL_CMP,   2},
            '{32'hFE00707F, 32'h00003033, ALU_SLTU, SEL_CMP,   2},
            '{32'hFE00707F, 32'h00004033, ALU_XOR,  SEL_LOGIC, 2},
            '{32'hFE00707F, 32'h00005033, ALU_SRL,  SEL_SHIFT, 2},
            '{32'hFE00707F, 32'h40005033, ALU_SRA,  SEL_SHIFT, 2},
            '{32'hFE00707F, 32'h00006033, ALU_OR,   SEL_LOGIC, 2},
            '{32'hFE00707F, 32'h00007033, ALU_AND,  SEL_LOGIC, 2},
            '{32'h0000007F, 32'h00000037, ALU_ADD,  SEL_ARITH, 3},
            '{32'h0000007F, 32'h00000017, ALU_ADD,  SEL_ARITH, 4}
        };
        tbl = '{
            '{32'hFFB00093, 32'h000, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b0, 1'b1, 5'd1, ALU_ADD,  SEL_ARITH, 32'h0,    32'hFFFFFFFB},
            '{32'h002081B3, 32'h004, 2'b11, 5'd1, 32'h11,   5'd1, 32'h22, 1'b0, 1'b1, 5'd3, ALU_ADD,  SEL_ARITH, 32'h11,   32'h1002},
            '{32'h002081B3, 32'h008, 2'b11, 5'd1, 32'h11,   5'd2, 32'h33, 1'b0, 1'b1, 5'd3, ALU_ADD,  SEL_ARITH, 32'h11,   32'h33},
            '{32'hFFFFFFFF, 32'h00C, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b0, 5'd0, ALU_NOP,  SEL_NOP,   32'h0,    32'h0},
            '{32'h00001297, 32'h100, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b0, 1'b1, 5'd5, ALU_ADD,  SEL_ARITH, 32'h100,  32'h1000},
            '{32'hFFFFF3B7, 32'h104, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b0, 1'b1, 5'd7, ALU_ADD,  SEL_ARITH, 32'h0,    32'hFFFFF000},
            '{32'h40208033, 32'h108, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b0, 1'b0, 5'd0, ALU_SUB,  SEL_ARITH, 32'h1001, 32'h1002},
            '{32'h4051D213, 32'h10C, 2'b10, 5'd3, 32'h99,   5'd4, 32'h77, 1'b0, 1'b1, 5'd4, ALU_SRA,  SEL_SHIFT, 32'h1003, 32'h5},
            '{32'h000000B3, 32'h110, 2'b01, 5'd0, 32'hDEAD, 5'd0, 32'h0,  1'b0, 1'b1, 5'd1, ALU_ADD,  SEL_ARITH, 32'h0,    32'h0},
            '{32'h02209093, 32'h114, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b0, 5'd0, ALU_NOP,  SEL_NOP,   32'h0,    32'h0},
            '{32'hFFF0B113, 32'h118, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b0, 1'b1, 5'd2, ALU_SLTU, SEL_CMP,   32'h1001, 32'hFFFFFFFF}
        };
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rst = 1'b1;
        in_valid = 1'b0;
        ex_load = 1'b0;
        flush = 1'b0;
        dif.out_ready = 1'b0;
        drive(32'h0, 32'h0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1 check_reset("reset");

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(tbl[i].inst, tbl[i].pc, tbl[i].fwe, tbl[i].fa0, tbl[i].fd0, tbl[i].fa1, tbl[i].fd1);
            in_valid = 1'b1;
            dif.out_ready = 1'b1;
            #1 chk($sformatf("tbl%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1 chk($sformatf("tbl%0d.valid", i), {31'd0, dif.out_valid}, 32'd1);
            e = '{default: '0};
            e.illegal = tbl[i].ill;
            e.we = tbl[i].we;
            e.waddr = tbl[i].waddr;
            e.aluop = tbl[i].aluop;
            e.alusel = tbl[i].alusel;
            e.op1 = tbl[i].op1;
            e.op2 = tbl[i].op2;
            check_out($sformatf("tbl%0d", i), e, tbl[i].pc);
        end

        // load-use stall, then release
        @(negedge clk);
        drive(32'h002081B3, 32'h200, 2'b01, 5'd1, 32'h55, 5'd0, 32'h0);
        ex_load = 1'b1;
        #1 chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 chk("stall.bubble", {31'd0, dif.out_valid}, 32'd0);
        @(negedge clk);
        ex_load = 1'b0;
        #1 chk("release.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 chk("release.valid", {31'd0, dif.out_valid}, 32'd1);
        chk("release.op1", dif.op1_o, 32'h55);
        chk("release.op2", dif.op2_o, 32'h1002);

        // backpressure hold, then flush
        snap_op1 = dif.op1_o;
        snap_op2 = dif.op2_o;
        snap_pc = dif.pc_o;
        @(negedge clk);
        dif.out_ready = 1'b0;
        drive(32'hFFB00093, 32'h300, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1 chk("hold.in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1 chk("hold.valid", {31'd0, dif.out_valid}, 32'd1);
            chk("hold.op1", dif.op1_o, snap_op1);
            chk("hold.op2", dif.op2_o, snap_op2);
            chk("hold.pc", dif.pc_o, snap_pc);
            @(negedge clk);
        end
        flush = 1'b1;
        #1 chk("flush.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 chk("flush.valid", {31'd0, dif.out_valid}, 32'd0);

        // reset while holding a stalled instruction
        @(negedge clk);
        flush = 1'b0;
        dif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.out_ready = 1'b0;
        drive(32'h002081B3, 32'h400, 2'b01, 5'd1, 32'h66, 5'd0, 32'h0);
        ex_load = 1'b1;
        @(posedge clk);
        #1 chk("pre_rst.valid", {31'd0, dif.out_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check_reset("rst_stall");

        // randomized run against the model
        @(negedge clk);
        rst = 1'b0;
        ex_load = 1'b0;
        in_valid = 1'b0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        m_valid = 1'b0;
        m = '{default: '0};
        m_pc = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 4) == 0) inst_i = $urandom;
            else begin
                int j;
                j = $urandom_range(0, 20);
                inst_i = ($urandom & ~pats[j].mask) | pats[j].match;
                inst_i[19:15] = 5'($urandom_range(0, 3));
                inst_i[24:20] = 5'($urandom_range(0, 3));
                inst_i[11:7] = 5'($urandom_range(0, 3));
            end
            pc_i = $urandom & 32'hFFFF_FFFC;
            fwd_we = 2'($urandom_range(0, 3));
            fwd_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            fwd_data = {$urandom, $urandom};
            in_valid = $urandom_range(0, 3) != 0;
            ex_load = $urandom_range(0, 3) == 0;
            flush = $urandom_range(0, 15) == 0;
            dif.out_ready = $urandom_range(0, 3) != 0;
            #1;
            e = model(inst_i, pc_i);
            hz = in_valid && haz(e, inst_i);
            rdy = (!m_valid || dif.out_ready) && !hz;
            chk("rand.in_ready", {31'd0, in_ready}, {31'd0, rdy});
            chk("rand.r1_en", {31'd0, r1_en}, {31'd0, in_valid && e.use1});
            chk("rand.r2_en", {31'd0, r2_en}, {31'd0, in_valid && e.use2});
            if (flush) m_valid = 1'b0;
            else if (in_valid && rdy) begin
                m_valid = 1'b1;
                m = e;
                m_pc = pc_i;
            end else if (!m_valid || dif.out_ready) m_valid = 1'b0;
            @(posedge clk);
            #1 chk("rand.valid", {31'd0, dif.out_valid}, {31'd0, m_valid});
            if (m_valid) check_out("rand", m, m_pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, sets the datapath and register width.
REQ-002 Parameter NUM_FWD, default 2, sets the forwarding source count; index 0 is the youngest (EX) source.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  upstream holds a valid pc_i/inst_i.
REQ-006 in_ready  out  1  stage accepts the input this cycle.
REQ-007 pc_i  in  XLEN  instruction address.
REQ-008 inst_i  in  32  instruction word.
REQ-009 r1_en_o, r2_en_o  out  1 each  regfile read enables (combinational).
REQ-010 r1_addr_o, r2_addr_o  out  5 each  regfile read addresses: inst_i[19:15] and inst_i[24:20].
REQ-011 r1_data_i, r2_data_i  in  XLEN each  regfile read data, same cycle.
REQ-012 fwd_we_i  in  NUM_FWD  forwarding write enables.
REQ-013 fwd_addr_i  in  5*NUM_FWD  packed forwarding destination addresses.
REQ-014 fwd_data_i  in  XLEN*NUM_FWD  packed forwarding data.
REQ-015 ex_load_i  in  1  instruction now in EX is a load; its rd is fwd_addr_i slot 0.
REQ-016 flush_i  in  1  kill the decoded and incoming instruction.
REQ-017 out_valid  out  1  registered outputs hold a valid instruction.
REQ-018 out_ready  in  1  downstream accepts the output.
REQ-019 aluop_o, alusel_o  out  8, 3  ALU operation and result select.
REQ-020 op1_o, op2_o  out  XLEN each  resolved operands.
REQ-021 we_o, waddr_o  out  1, 5  writeback enable and destination register.
REQ-022 pc_o  out  XLEN  pc of the decoded instruction.
REQ-023 illegal_o  out  1  unsupported encoding.

Function
REQ-024 Decode SHALL cover OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), OP (10 R-type ops), LUI and AUIPC.
REQ-025 I-immediate SHALL be sign-extended to XLEN; shift amount = inst[24:20]; U-immediate = {inst[31:12], 12'b0}, sign-extended.
REQ-026 op1 selection: rs1 for OP/OP-IMM; zero for LUI; pc_i for AUIPC.
REQ-027 op2 selection: rs2 for OP; immediate otherwise.
REQ-028 Operand resolution priority: lowest-index fwd slot with we=1 and address match; else regfile data.
REQ-029 A source address of x0 SHALL resolve to 0, never to forwarded or regfile data.
REQ-030 Any unlisted opcode/funct3/funct7 SHALL give illegal_o=1 with we_o=0, aluop=NOP, alusel=NOP, still presented with out_valid.
REQ-031 rd=x0 SHALL force we_o=0.
REQ-032 Load-use hazard: ex_load_i=1, fwd_we_i[0]=1, and fwd_addr slot 0 equal to a used nonzero source -> hazard.
REQ-033 load_stall = in_valid & hazard.
REQ-034 in_ready = (~out_valid | out_ready) & ~load_stall.
REQ-035 On accept (in_valid & in_ready & ~flush_i), the output registers SHALL load the decode result next edge with out_valid=1 (latency 1 cycle).
REQ-036 On load_stall with (~out_valid | out_ready), the stage SHALL insert a bubble: out_valid=0 next cycle; input held upstream.
REQ-037 When out_valid & ~out_ready, all outputs SHALL hold stable.
REQ-038 When out_ready=1 and there is no accept, out_valid SHALL clear.
REQ-039 flush_i SHALL have priority over accept, stall and hold: out_valid=0 next edge, input dropped, in_ready unaffected.

Reset
REQ-040 With rst high at an edge, next state SHALL be: out_valid=0, we_o=0, waddr_o=0, aluop_o/alusel_o=NOP, op1_o/op2_o/pc_o=0, illegal_o=0.
REQ-041 Reset SHALL abort any in-progress stall or hold; rst overrides flush_i and accept.

Structure
REQ-042 ALU op/sel codes, opcode/funct constants and the NOP encodings SHALL live in the shared CPU defines package.
REQ-043 Operand resolution SHALL be one sub-module, operand_fwd (parameters XLEN, NUM_FWD), instantiated twice.

Verification
REQ-044 ADDI x1,x0,-5 (0xFFB00093), out_ready=1 -> next cycle out_valid=1, op1=0, op2=0xFFFFFFFB, we=1, waddr=1.
REQ-045 ADD x3,x1,x2 with fwd0=(x1,0x11), fwd1=(x1,0x22) and fwd1=(x2,0x33) -> op1=0x11, op2=0x33.
REQ-046 ex_load_i=1, fwd0 addr=x1, input ADD x3,x1,x2 -> in_ready=0, out_valid=0 next cycle; after ex_load_i drops, accept with 1-cycle latency.
REQ-047 out_ready=0 for 3 cycles with a valid output -> outputs stable, in_ready=0; flush_i then asserted -> out_valid=0 next cycle.
REQ-048 Input 0xFFFFFFFF -> illegal_o=1, we_o=0; AUIPC x5,0x1 at pc=0x100 -> op1=0x100, op2=0x1000.
REQ-049 rst asserted while stalled -> all outputs at REQ-040 values next cycle.
